// File: rtl/keccak_masked_round_sequencer.sv
// Iterative masked Keccak-f[25*W] round sequencer. Linear steps run share-wise in one
// cycle; chi is streamed row by row through an external one-cycle DOM S-box.
module keccak_masked_round_sequencer #(
    parameter int SHARES = 2,
    parameter int W      = 4
) (
    input  logic                      ClkxCI,
    input  logic                      RstxRBI,
    input  logic                      StartxSI,
    input  logic [SHARES*25*W-1:0]    StatexDI,
    output logic [SHARES*25*W-1:0]    StatexDO,
    output logic                      BusyxSO,
    output logic                      DonexSO,
    output logic                      RandReqxSO,
    output logic [SHARES*5-1:0]       SboxInxDO,
    input  logic [SHARES*5-1:0]       SboxOutxDI
);
    localparam int L    = $clog2(W);
    localparam int NR   = 12 + 2 * L;
    localparam int SW   = 25 * W;
    localparam int ROWS = 5 * W;
    localparam int RW   = $clog2(ROWS);
    localparam int NRW  = $clog2(NR);

    // Bit (2^j - 1) of round ir's constant is rc(j + 7*ir); the LFSR is stepped once per k.
    function automatic logic [NR*W-1:0] gen_rc();
        logic [NR*W-1:0] t;
        logic [7:0]      r;
        t = '0;
        r = 8'h01;
        for (int k = 0; k < 7 * NR; k++) begin
            if ((k % 7) <= L) t[(k / 7) * W + (1 << (k % 7)) - 1] = r[0];
            r = r[7] ? ((r << 1) ^ 8'h71) : (r << 1);
        end
        return t;
    endfunction

    localparam logic [NR*W-1:0] RC_TAB = gen_rc();

    function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int z = 0; z < W; z++) r[(z + n) % W] = a[z];
        return r;
    endfunction

    function automatic logic [SW-1:0] lin_step(input logic [SW-1:0] a);
        logic [W-1:0]  c [5];
        logic [W-1:0]  d [5];
        logic [W-1:0]  lane;
        logic [SW-1:0] b;
        int            off [25];
        int            x, y, nx;
        // rho offsets follow the (x,y) -> (y, 2x+3y) walk starting at lane (1,0)
        off[0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            off[5 * y + x] = ((t + 1) * (t + 2) / 2) % W;
            nx = y;
            y  = (2 * x + 3 * y) % 5;
            x  = nx;
        end
        for (int i = 0; i < 5; i++) begin
            c[i] = '0;
            for (int j = 0; j < 5; j++) c[i] = c[i] ^ a[(5 * j + i) * W +: W];
        end
        for (int i = 0; i < 5; i++) d[i] = c[(i + 4) % 5] ^ rotl(c[(i + 1) % 5], 1);
        b = '0;
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 5; i++) begin
                lane = a[(5 * j + i) * W +: W] ^ d[i];
                b[(5 * ((2 * i + 3 * j) % 5) + j) * W +: W] = rotl(lane, off[5 * j + i]);
            end
        end
        return b;
    endfunction

    typedef enum logic [2:0] {IDLE, LIN, CHI, DRAIN, DONE} fsm_e;

    fsm_e                      fsm_q;
    logic [SHARES*SW-1:0]      state_q;
    logic [SHARES*SW-1:0]      lin_d;
    logic [SHARES*SW-1:0]      wb_d;
    logic [SHARES*5-1:0]       sbox_row;
    logic [NRW-1:0]            round_q;
    logic [RW-1:0]             row_q;
    logic [RW-1:0]             wb_row;
    logic                      busy_q, done_q, rreq_q;
    logic                      rc_bit;
    int                        wy, wz, ry, rz;

    always_comb begin
        lin_d = '0;
        for (int i = 0; i < SHARES; i++) lin_d[i*SW +: SW] = lin_step(state_q[i*SW +: SW]);
    end

    // Write-back targets the row issued one cycle earlier; DRAIN finishes the last row.
    always_comb begin
        wb_row   = (fsm_q == DRAIN) ? RW'(ROWS - 1) : row_q - 1'b1;
        wy       = int'(wb_row) / W;
        wz       = int'(wb_row) % W;
        ry       = int'(row_q) / W;
        rz       = int'(row_q) % W;
        rc_bit   = RC_TAB[int'(round_q) * W + wz];
        wb_d     = state_q;
        sbox_row = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int x = 0; x < 5; x++) begin
                wb_d[i*SW + (5*wy + x)*W + wz] = SboxOutxDI[i*5 + x] ^
                    ((i == 0) && (x == 0) && (wy == 0) && rc_bit);
                sbox_row[i*5 + x] = state_q[i*SW + (5*ry + x)*W + rz];
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rreq_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (StartxSI) begin
                        state_q <= StatexDI;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        fsm_q   <= LIN;
                    end
                end
                LIN: begin
                    state_q <= lin_d;
                    row_q   <= '0;
                    rreq_q  <= 1'b1;
                    fsm_q   <= CHI;
                end
                CHI: begin
                    if (row_q != '0) state_q <= wb_d;
                    if (row_q == RW'(ROWS - 1)) begin
                        rreq_q <= 1'b0;
                        fsm_q  <= DRAIN;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_q <= wb_d;
                    if (round_q == NRW'(NR - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= DONE;
                    end else begin
                        round_q <= round_q + 1'b1;
                        fsm_q   <= LIN;
                    end
                end
                DONE:    fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign StatexDO   = state_q;
    assign BusyxSO    = busy_q;
    assign DonexSO    = done_q;
    assign RandReqxSO = rreq_q;
    assign SboxInxDO  = (fsm_q == CHI) ? sbox_row : '0;

endmodule

// File: tb/tb_keccak_masked_round_sequencer.sv
// Bench for keccak_masked_round_sequencer (SHARES=2, W=4) with a behavioural masked
// chi S-box and a Keccak-f[100] reference model feeding a result scoreboard.
module tb_keccak_masked_round_sequencer;
    localparam int SHARES = 2;
    localparam int W      = 4;

    logic         ClkxCI = 1'b0;
    logic         RstxRBI = 1'b0;
    logic         StartxSI = 1'b0;
    logic [199:0] StatexDI = '0;
    logic [199:0] StatexDO;
    logic         BusyxSO, DonexSO, RandReqxSO;
    logic [9:0]   SboxInxDO;
    logic [9:0]   SboxOutxDI;
    logic [9:0]   sbox_q = '0;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0, rreq_cnt = 0, done_cnt = 0, sbox_bad = 0;
    logic [99:0] exp_q [$];

    keccak_masked_round_sequencer #(.SHARES(SHARES), .W(W)) dut (
        .ClkxCI     (ClkxCI),
        .RstxRBI    (RstxRBI),
        .StartxSI   (StartxSI),
        .StatexDI   (StatexDI),
        .StatexDO   (StatexDO),
        .BusyxSO    (BusyxSO),
        .DonexSO    (DonexSO),
        .RandReqxSO (RandReqxSO),
        .SboxInxDO  (SboxInxDO),
        .SboxOutxDI (SboxOutxDI)
    );

    always #5 ClkxCI = ~ClkxCI;

    // Rotation offsets mod 4, indexed [5y+x]; round constants of Keccak-f[100].
    localparam logic [1:0] RHO [25] = '{0,1,2,0,3, 0,0,2,3,0, 3,2,3,1,3, 1,1,3,1,0, 2,2,1,0,2};
    localparam logic [3:0] RC  [16] = '{4'h1,4'h2,4'hA,4'h0,4'hB,4'h1,4'h1,4'h9,
                                        4'hA,4'h8,4'h9,4'hA,4'hB,4'hB,4'h9,4'h3};

    function automatic logic [3:0] rol4(input logic [3:0] v, input int n);
        logic [7:0] t;
        t = {v, v} << n;
        return t[7:4];
    endfunction

    function automatic logic [99:0] kround(input logic [99:0] s, input int ir);
        logic [3:0] a [25];
        logic [3:0] b [25];
        logic [3:0] c [5];
        logic [3:0] d;
        logic [99:0] r;
        for (int i = 0; i < 25; i++) a[i] = s[i*4 +: 4];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) begin
            d = c[(x+4)%5] ^ rol4(c[(x+1)%5], 1);
            for (int y = 0; y < 5; y++) a[5*y+x] = a[5*y+x] ^ d;
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[5*((2*x+3*y)%5) + y] = rol4(a[5*y+x], int'(RHO[5*y+x]));
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[5*y+x] = b[5*y+x] ^ (~b[5*y+(x+1)%5] & b[5*y+(x+2)%5]);
        a[0] = a[0] ^ RC[ir];
        for (int i = 0; i < 25; i++) r[i*4 +: 4] = a[i];
        return r;
    endfunction

    function automatic logic [99:0] kf(input logic [99:0] s);
        logic [99:0] t;
        t = s;
        for (int ir = 0; ir < 16; ir++) t = kround(t, ir);
        return t;
    endfunction

    function automatic logic [9:0] sbox_model(input logic [9:0] in, input logic [4:0] m);
        logic [4:0] u, o;
        u = in[4:0] ^ in[9:5];
        for (int x = 0; x < 5; x++) o[x] = u[x] ^ (~u[(x+1)%5] & u[(x+2)%5]);
        return {m, o ^ m};
    endfunction

    function automatic logic [99:0] rnd100();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[99:0];
    endfunction

    always @(posedge ClkxCI) sbox_q <= sbox_model(SboxInxDO, 5'($urandom()));
    assign SboxOutxDI = sbox_q;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor
    always @(negedge ClkxCI) begin
        if (RstxRBI) begin
            if (BusyxSO) busy_cnt++;
            if (RandReqxSO) rreq_cnt++;
            if (!RandReqxSO && SboxInxDO !== 10'd0) sbox_bad++;
            if (DonexSO) begin
                done_cnt++;
                if (exp_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
                else chk("result", StatexDO[99:0] ^ StatexDO[199:100], exp_q.pop_front());
            end
        end
    end

    task automatic clear_counts();
        busy_cnt = 0; rreq_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_run(input logic [199:0] st);
        StatexDI = st;
        StartxSI = 1'b1;
        @(posedge ClkxCI);
        #1;
        StartxSI = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!DonexSO && n < bound) begin
            @(negedge ClkxCI);
            n++;
        end
        chk("done_timeout", DonexSO, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [99:0] m, mask, m2;
        logic [199:0] tmp;

        // reset state
        #12;
        chk("rst_state", StatexDO, '0);
        chk("rst_busy", BusyxSO, 1'b0);
        chk("rst_done", DonexSO, 1'b0);
        chk("rst_rreq", RandReqxSO, 1'b0);
        chk("rst_sboxin", SboxInxDO, '0);
        repeat (2) @(posedge ClkxCI);
        #1 RstxRBI = 1'b1;
        repeat (2) @(posedge ClkxCI);
        #1;

        // zero state
        clear_counts();
        exp_q.push_back(kf('0));
        start_run('0);
        wait_done(400);
        @(posedge ClkxCI);
        #1;
        chk("busy_cycles", busy_cnt, 352);
        chk("rreq_cycles", rreq_cnt, 320);
        chk("done_pulses", done_cnt, 1);
        chk("idle_busy", BusyxSO, 1'b0);
        chk("idle_hold", StatexDO[99:0] ^ StatexDO[199:100], kf('0));

        // masked random state, single round probe
        m    = rnd100();
        mask = rnd100();
        clear_counts();
        exp_q.push_back(kf(m));
        start_run({mask, m ^ mask});
        repeat (22) @(posedge ClkxCI);
        #1;
        chk("one_round", StatexDO[99:0] ^ StatexDO[199:100], kround(m, 0));
        chk("one_round_rreq", rreq_cnt, 20);
        wait_done(400);
        @(posedge ClkxCI);
        #1;
        chk("share0_masked", StatexDO[99:0] != kf(m), 1'b1);
        chk("done_pulses_b", done_cnt, 1);

        // StartxSI held high, StatexDI changing while busy
        m  = rnd100();
        m2 = rnd100();
        clear_counts();
        exp_q.push_back(kf(m));
        StatexDI = {100'd0, m};
        StartxSI = 1'b1;
        @(posedge ClkxCI);
        #1;
        StatexDI = {100'd0, m2};
        exp_q.push_back(kf(m2));
        wait_done(400);
        @(posedge ClkxCI);
        #1;
        chk("restart_idle", BusyxSO, 1'b0);
        @(posedge ClkxCI);
        #1;
        chk("restart_busy", BusyxSO, 1'b1);
        tmp = {rnd100(), rnd100()};
        StatexDI = tmp;
        StartxSI = 1'b0;
        wait_done(400);
        @(posedge ClkxCI);
        #1;
        chk("done_pulses_c", done_cnt, 2);

        // reset at CHI row 7 of round 3
        clear_counts();
        start_run({rnd100(), rnd100()});
        repeat (74) @(posedge ClkxCI);
        #1;
        chk("abort_in_chi", RandReqxSO, 1'b1);
        RstxRBI = 1'b0;
        #1;
        chk("abort_state", StatexDO, '0);
        chk("abort_busy", BusyxSO, 1'b0);
        chk("abort_rreq", RandReqxSO, 1'b0);
        chk("abort_sboxin", SboxInxDO, '0);
        repeat (3) @(posedge ClkxCI);
        #1 RstxRBI = 1'b1;
        repeat (5) @(posedge ClkxCI);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", BusyxSO, 1'b0);

        // fresh start after abort
        m    = rnd100();
        mask = rnd100();
        exp_q.push_back(kf(m));
        start_run({mask, m ^ mask});
        wait_done(400);
        @(posedge ClkxCI);
        #1;
        chk("sboxin_idle_zero", sbox_bad, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
